pi_pipeline_mc: RTL and testbench
=================================

# pi_pipeline_mc

Multi-channel, time-multiplexed successor to the single-channel PI pipeline. Holds per-channel integral state internally, not fed back by the caller. Adds a valid handshake, channel tagging, integral anti-windup clamping, fixed-point output scaling and a sequenced integral-clear mode. Sits between the ADC sample sequencer and the DAC/output arbiter in the feedback loop.

## Interface
- `INPUT_WIDTH`, 18: signed setpoint/actual width.
- `OUTPUT_WIDTH`, 32: signed error, integral, gain and result width; must be ≥ `INPUT_WIDTH`+1.
- `CHANNELS`, 4: number of independent loops; ≥ 1.
- `CH_W`, `$clog2(CHANNELS)` (min 1): channel index width.
- `FRAC_BITS`, 0: arithmetic right shift applied to the 2·`OUTPUT_WIDTH` sum before saturation; range 0..`OUTPUT_WIDTH`-1.
- `OUT_LB` / `OUT_UB`, -32'sh80000 / 32'sh7FFFF: result saturation bounds, signed.
- `INT_LB` / `INT_UB`, -32'sh80000000 / 32'sh7FFFFFFF: integral anti-windup bounds, signed.
- `clk`  in  1  sole clock, rising edge.
- `rst_L`  in  1  reset; asynchronous assert, active-low, synchronous deassert is the system's responsibility.
- `kp_flat`  in  `CHANNELS`·`OUTPUT_WIDTH`  per-channel proportional gain, channel c at bits [c·W +: W]; signed.
- `ki_flat`  in  `CHANNELS`·`OUTPUT_WIDTH`  per-channel integral gain, same packing.
- `in_valid`  in  1  sample present.
- `in_ready`  out  1  block accepts; a sample transfers when `in_valid && in_ready`.
- `in_ch`  in  `CH_W`  channel of sample; values ≥ `CHANNELS` are accepted and dropped (no state change, no output).
- `setpoint`, `actual`  in  `INPUT_WIDTH`  signed.
- `clear_req`  in  1  one-cycle pulse: zero all integrals.
- `out_valid`  out  1  result present (one-cycle strobe, no backpressure).
- `out_ch`  out  `CH_W`  channel of result.
- `pi_result`  out  `OUTPUT_WIDTH`  saturated result.
- `integral_result`  out  `OUTPUT_WIDTH`  clamped integral for the same sample.
- `sat_flag`  out  1  result was saturated (either bound).

## Operation
- FSM states `RUN`, `CLEAR`. Reset → `RUN`.
- `RUN`: `in_ready`=1. `clear_req` → `CLEAR` next cycle, clear counter = 0.
- `CLEAR`: `in_ready`=0. Writes `integral[counter]`=0, one channel per cycle; after channel `CHANNELS`-1 → `RUN`. `clear_req` during `CLEAR` is ignored. Samples already in flight complete normally. An S2 write to the same channel in the same cycle loses to the clear.
- Error: `actual − setpoint`, sign-extended to `OUTPUT_WIDTH`.
- Integral: `integral[ch] + error`, computed at `OUTPUT_WIDTH`+1 bits. Clamped to [`INT_LB`, `INT_UB`] and written back in the same stage.
- Result: `(integral·ki + error·kp) >>> FRAC_BITS`, full 2·`OUTPUT_WIDTH` precision. Saturated to [`OUT_LB`, `OUT_UB`] via upper-word sign/ones check plus lower-word compare.

## Timing
- Pipeline, one sample per cycle when `in_ready`:
  - S1: register error, channel and valid.
  - S2: read/modify/clamp/write integral (register array, combinational read).
  - S3: both multiplies.
  - S4: sum.
  - S5: shift and saturation flags.
  - S6: output.
- Latency: accepted at edge N → `out_valid` high in cycle N+6.
- Same channel on consecutive cycles must use the updated integral (S2 read follows the prior write with no hazard); bench checks this.
- Reset, including mid-pipeline: all valids 0, integrals 0, `pi_result`/`integral_result`/`out_ch`/`sat_flag` = 0, FSM `RUN`, `in_ready` = 1 after release. In-flight samples are discarded.
- `clear_req` is latched at edge N. `in_ready` is low for cycles N+1..N+`CHANNELS`, then high.

## Structure
- `pi_pkg`:
  - FSM state enum;
  - saturation helper function (value, lb, ub → clamped, flag), shared by integral and output clamps.
- Sub-module `pi_sat_stage`: S5/S6 shift-and-saturate, parametrised on width, `FRAC_BITS` and bounds. Reused later for single-channel variants.

## Test plan
- Ch0, kp=2, ki=1, setpoint=0, actual=10, one sample → cycle N+6: out_ch=0, integral_result=10, pi_result=30, sat_flag=0.
- Ch1 twice back-to-back, actual=5, setpoint=0, kp=0, ki=1 → results 5 then 10. Ch0 integral remains unchanged.
- Ki=1, kp=0, INT_UB=100, repeated error 60 → integral 60, then 100, 100; a later error of −10 gives 90 (no windup).
- kp=0x10000, error=0x7FFFF, FRAC_BITS=0 → pi_result=OUT_UB, sat_flag=1. Negative mirror → OUT_LB.
- Load all channels, pulse clear_req → in_ready low `CHANNELS` cycles. Next sample with error 3, ki=1 gives integral 3.
- Assert rst_L low mid-stream for 1 cycle → no out_valid from pre-reset samples, all outputs 0, integrals 0.

Source files
------------

// File: rtl/pi_pkg.sv
// Shared types for the multi-channel PI pipeline: controller state and the
// signed clamp helper used by both the integral and the output saturators.
package pi_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Wide enough for a 2*OUTPUT_WIDTH product with OUTPUT_WIDTH up to 64.
  localparam int SAT_W = 128;

  typedef struct packed {
    logic signed [SAT_W-1:0] value;
    logic                    hi;
    logic                    lo;
  } sat_t;

  function automatic sat_t sat_clamp(input logic signed [SAT_W-1:0] v,
                                     input logic signed [SAT_W-1:0] lb,
                                     input logic signed [SAT_W-1:0] ub);
    sat_t r;
    r.value = v;
    r.hi    = 1'b0;
    r.lo    = 1'b0;
    if (v > ub) begin
      r.value = ub;
      r.hi    = 1'b1;
    end else if (v < lb) begin
      r.value = lb;
      r.lo    = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pi_sat_stage.sv
// Two-stage shift-and-saturate: arithmetic right shift of a double-width sum,
// then clamp to [LB, UB] using an upper-word sign check plus lower-word compare.
module pi_sat_stage
  import pi_pkg::*;
#(
  parameter int                       WIDTH     = 32,
  parameter int                       FRAC_BITS = 0,
  parameter logic signed [WIDTH-1:0]  LB        = {1'b1, {(WIDTH-1){1'b0}}},
  parameter logic signed [WIDTH-1:0]  UB        = {1'b0, {(WIDTH-1){1'b1}}}
) (
  input  logic                       clk,
  input  logic                       rst_L,
  input  logic                       in_vld,
  input  logic signed [2*WIDTH-1:0]  sum,
  output logic                       out_vld,
  output logic signed [WIDTH-1:0]    result,
  output logic                       sat_flag
);

  logic signed [2*WIDTH-1:0] shifted;
  logic signed [WIDTH-1:0]   low;
  logic                      fits;
  sat_t                      low_sat;
  logic                      unused_low_value;

  logic                      vld_p5;
  logic signed [WIDTH-1:0]   low_p5;
  logic                      hi_p5;
  logic                      lo_p5;

  assign shifted = sum >>> FRAC_BITS;
  assign low     = shifted[WIDTH-1:0];
  // Upper word must be pure sign extension of the lower word to fit at all.
  assign fits    = (shifted[2*WIDTH-1:WIDTH] == {WIDTH{shifted[WIDTH-1]}});
  assign low_sat = sat_clamp(SAT_W'(low), SAT_W'(LB), SAT_W'(UB));
  assign unused_low_value = ^low_sat.value;

  // S5: shift and saturation flags
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) vld_p5 <= 1'b0;
    else        vld_p5 <= in_vld;
  end

  always_ff @(posedge clk) begin
    low_p5 <= low;
    hi_p5  <= fits ? low_sat.hi : ~shifted[2*WIDTH-1];
    lo_p5  <= fits ? low_sat.lo :  shifted[2*WIDTH-1];
  end

  // S6: output register
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      out_vld  <= 1'b0;
      result   <= '0;
      sat_flag <= 1'b0;
    end else begin
      out_vld <= vld_p5;
      if (vld_p5) begin
        result   <= hi_p5 ? UB : (lo_p5 ? LB : low_p5);
        sat_flag <= hi_p5 | lo_p5;
      end
    end
  end

endmodule

// File: rtl/pi_pipeline_mc.sv
// Time-multiplexed multi-channel PI controller: per-channel integral state,
// anti-windup clamp, scaled/saturated output, and a sequenced integral clear.
module pi_pipeline_mc
  import pi_pkg::*;
#(
  parameter int INPUT_WIDTH  = 18,
  parameter int OUTPUT_WIDTH = 32,
  parameter int CHANNELS     = 4,
  parameter int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int FRAC_BITS    = 0,
  parameter logic signed [OUTPUT_WIDTH-1:0] OUT_LB = -32'sh80000,
  parameter logic signed [OUTPUT_WIDTH-1:0] OUT_UB = 32'sh7FFFF,
  parameter logic signed [OUTPUT_WIDTH-1:0] INT_LB = -32'sh80000000,
  parameter logic signed [OUTPUT_WIDTH-1:0] INT_UB = 32'sh7FFFFFFF
) (
  input  logic                               clk,
  input  logic                               rst_L,
  input  logic [CHANNELS*OUTPUT_WIDTH-1:0]   kp_flat,
  input  logic [CHANNELS*OUTPUT_WIDTH-1:0]   ki_flat,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [CH_W-1:0]                    in_ch,
  input  logic signed [INPUT_WIDTH-1:0]      setpoint,
  input  logic signed [INPUT_WIDTH-1:0]      actual,
  input  logic                               clear_req,
  output logic                               out_valid,
  output logic [CH_W-1:0]                    out_ch,
  output logic signed [OUTPUT_WIDTH-1:0]     pi_result,
  output logic signed [OUTPUT_WIDTH-1:0]     integral_result,
  output logic                               sat_flag
);

  localparam int W  = OUTPUT_WIDTH;
  localparam int W2 = 2 * OUTPUT_WIDTH;
  localparam int IW = INPUT_WIDTH;

  state_t          state, state_nxt;
  logic [CH_W-1:0] clr_cnt;
  logic            clr_we;
  logic            clr_last;

  assign clr_last = (clr_cnt == CH_W'(CHANNELS - 1));

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state   <= RUN;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == RUN) clr_cnt <= '0;
      else              clr_cnt <= clr_cnt + CH_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    clr_we    = 1'b0;
    case (state)
      RUN: begin
        in_ready = 1'b1;
        if (clear_req) state_nxt = CLEAR;
      end
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_last) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  logic signed [IW:0]  diff;
  logic signed [W-1:0] err;
  logic                ch_ok;

  assign diff  = {actual[IW-1], actual} - {setpoint[IW-1], setpoint};
  assign err   = W'(diff);
  assign ch_ok = ({1'b0, in_ch} < (CH_W+1)'(CHANNELS));

  logic                vld_p1;
  logic signed [W-1:0] err_p1;
  logic [CH_W-1:0]     ch_p1;

  // S1: register error, channel and valid
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) vld_p1 <= 1'b0;
    else        vld_p1 <= in_valid && in_ready && ch_ok;
  end

  always_ff @(posedge clk) begin
    err_p1 <= err;
    ch_p1  <= in_ch;
  end

  logic signed [W-1:0] integ [CHANNELS];
  logic signed [W-1:0] int_rd;
  logic signed [W:0]   isum;
  sat_t                int_sat;
  logic signed [W-1:0] int_new;
  logic                unused_int_bits;

  assign int_rd  = integ[ch_p1];
  assign isum    = {int_rd[W-1], int_rd} + {err_p1[W-1], err_p1};
  assign int_sat = sat_clamp(SAT_W'(isum), SAT_W'(INT_LB), SAT_W'(INT_UB));
  assign int_new = int_sat.value[W-1:0];
  assign unused_int_bits = ^{int_sat.value[SAT_W-1:W], int_sat.hi, int_sat.lo};

  // S2: read/modify/clamp/write integral; a clear of the same channel wins
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      for (int c = 0; c < CHANNELS; c++) integ[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (clr_we && clr_cnt == CH_W'(c))     integ[c] <= '0;
        else if (vld_p1 && ch_p1 == CH_W'(c))  integ[c] <= int_new;
      end
    end
  end

  logic                vld_p2;
  logic signed [W-1:0] err_p2;
  logic signed [W-1:0] int_p2;
  logic [CH_W-1:0]     ch_p2;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) vld_p2 <= 1'b0;
    else        vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    err_p2 <= err_p1;
    int_p2 <= int_new;
    ch_p2  <= ch_p1;
  end

  logic signed [W-1:0]  kp_sel;
  logic signed [W-1:0]  ki_sel;
  logic                 vld_p3;
  logic signed [W2-1:0] prod_i_p3;
  logic signed [W2-1:0] prod_p_p3;
  logic signed [W-1:0]  int_p3;
  logic [CH_W-1:0]      ch_p3;

  assign kp_sel = kp_flat[int'(ch_p2)*W +: W];
  assign ki_sel = ki_flat[int'(ch_p2)*W +: W];

  // S3: both multiplies at full double width
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) vld_p3 <= 1'b0;
    else        vld_p3 <= vld_p2;
  end

  always_ff @(posedge clk) begin
    prod_i_p3 <= W2'(int_p2) * W2'(ki_sel);
    prod_p_p3 <= W2'(err_p2) * W2'(kp_sel);
    int_p3    <= int_p2;
    ch_p3     <= ch_p2;
  end

  logic                 vld_p4;
  logic signed [W2-1:0] sum_p4;
  logic signed [W-1:0]  int_p4;
  logic [CH_W-1:0]      ch_p4;

  // S4: sum
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) vld_p4 <= 1'b0;
    else        vld_p4 <= vld_p3;
  end

  always_ff @(posedge clk) begin
    sum_p4 <= prod_i_p3 + prod_p_p3;
    int_p4 <= int_p3;
    ch_p4  <= ch_p3;
  end

  pi_sat_stage #(
    .WIDTH     (W),
    .FRAC_BITS (FRAC_BITS),
    .LB        (OUT_LB),
    .UB        (OUT_UB)
  ) u_sat (
    .clk      (clk),
    .rst_L    (rst_L),
    .in_vld   (vld_p4),
    .sum      (sum_p4),
    .out_vld  (out_valid),
    .result   (pi_result),
    .sat_flag (sat_flag)
  );

  logic                vld_p5;
  logic signed [W-1:0] int_p5;
  logic [CH_W-1:0]     ch_p5;

  // S5: sideband follows the saturator
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) vld_p5 <= 1'b0;
    else        vld_p5 <= vld_p4;
  end

  always_ff @(posedge clk) begin
    int_p5 <= int_p4;
    ch_p5  <= ch_p4;
  end

  // S6: output sideband registers
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      out_ch          <= '0;
      integral_result <= '0;
    end else if (vld_p5) begin
      out_ch          <= ch_p5;
      integral_result <= int_p5;
    end
  end

endmodule

// File: tb/tb_pi_pipeline_mc.sv
// Directed bench for pi_pipeline_mc: table of single-sample vectors plus
// hand-written back-to-back, clear-sequence and mid-stream reset scenarios.
module tb_pi_pipeline_mc;

  localparam int IW  = 20;
  localparam int W   = 32;
  localparam int CH  = 4;
  localparam int CHW = 2;
  localparam int NV  = 11;

  logic                  clk = 1'b0;
  logic                  rst_L;
  logic [CH*W-1:0]       kp_flat;
  logic [CH*W-1:0]       ki_flat;
  logic                  in_valid;
  logic                  in_ready;
  logic [CHW-1:0]        in_ch;
  logic signed [IW-1:0]  setpoint;
  logic signed [IW-1:0]  actual;
  logic                  clear_req;
  logic                  out_valid;
  logic [CHW-1:0]        out_ch;
  logic signed [W-1:0]   pi_result;
  logic signed [W-1:0]   integral_result;
  logic                  sat_flag;

  always #5 clk = ~clk;

  pi_pipeline_mc #(
    .INPUT_WIDTH  (IW),
    .OUTPUT_WIDTH (W),
    .CHANNELS     (CH),
    .CH_W         (CHW),
    .FRAC_BITS    (0),
    .OUT_LB       (-32'sh80000),
    .OUT_UB       (32'sh7FFFF),
    .INT_LB       (-32'sd100),
    .INT_UB       (32'sd100)
  ) dut (
    .clk             (clk),
    .rst_L           (rst_L),
    .kp_flat         (kp_flat),
    .ki_flat         (ki_flat),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_ch           (in_ch),
    .setpoint        (setpoint),
    .actual          (actual),
    .clear_req       (clear_req),
    .out_valid       (out_valid),
    .out_ch          (out_ch),
    .pi_result       (pi_result),
    .integral_result (integral_result),
    .sat_flag        (sat_flag)
  );

  typedef struct {
    int ch;
    int sp;
    int act;
    int kp;
    int ki;
    int exp_int;
    int exp_pi;
    bit exp_sat;
  } vec_t;

  vec_t vecs [NV];
  int   errors = 0;
  int   checks = 0;
  int   lows;
  int   seen;
  bit   seen_high;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_gain(input int c, input int kp, input int ki);
    kp_flat[c*W +: W] = kp;
    ki_flat[c*W +: W] = ki;
  endtask

  task automatic send(input int c, input int sp, input int act);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_ch    = CHW'(c);
    setpoint = IW'(sp);
    actual   = IW'(act);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic expect_out(input string tag, input int exp_lat, input int c,
                            input int ei, input int ep, input bit es);
    int lat;
    wait_out(lat);
    check({tag, "_latency"}, lat, exp_lat);
    if (lat >= 0) begin
      check({tag, "_ch"},  32'(out_ch), c);
      check({tag, "_int"}, integral_result, ei);
      check({tag, "_pi"},  pi_result, ep);
      check({tag, "_sat"}, 32'(sat_flag), 32'(es));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    //            ch  sp        act       kp        ki  int    pi        sat
    vecs[0]  = '{0,  0,        10,       2,        1,  10,    30,       1'b0};
    vecs[1]  = '{2,  0,        60,       0,        1,  60,    60,       1'b0};
    vecs[2]  = '{2,  0,        60,       0,        1,  100,   100,      1'b0};
    vecs[3]  = '{2,  0,        60,       0,        1,  100,   100,      1'b0};
    vecs[4]  = '{2,  10,       0,        0,        1,  90,    90,       1'b0};
    vecs[5]  = '{3,  0,        'h7FFFF,  'h10000,  0,  100,   'h7FFFF,  1'b1};
    vecs[6]  = '{3,  0,        -'h7FFFF, 'h10000,  0,  -100,  -'h80000, 1'b1};
    vecs[7]  = '{3,  0,        'h40000,  2,        0,  100,   'h7FFFF,  1'b1};
    vecs[8]  = '{3,  0,        'h7FFFF,  1,        0,  100,   'h7FFFF,  1'b0};
    vecs[9]  = '{3,  0,        -'h80000, 1,        0,  -100,  -'h80000, 1'b0};
    vecs[10] = '{0,  5,        1,        -3,       2,  6,     24,       1'b0};

    rst_L     = 1'b1;
    in_valid  = 1'b0;
    in_ch     = '0;
    setpoint  = '0;
    actual    = '0;
    clear_req = 1'b0;
    kp_flat   = '0;
    ki_flat   = '0;
    #2 rst_L = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_pi",        pi_result, 0);
    check("rst_int",       integral_result, 0);
    check("rst_ch",        32'(out_ch), 0);
    check("rst_sat",       32'(sat_flag), 0);
    @(posedge clk); #1;
    rst_L = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready), 1);

    for (int i = 0; i < NV; i++) begin
      set_gain(vecs[i].ch, vecs[i].kp, vecs[i].ki);
      send(vecs[i].ch, vecs[i].sp, vecs[i].act);
      expect_out($sformatf("vec%0d", i), 5, vecs[i].ch, vecs[i].exp_int,
                 vecs[i].exp_pi, vecs[i].exp_sat);
    end

    // Same channel on consecutive cycles must see the freshly written integral.
    set_gain(1, 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b1; in_ch = 2'd1; setpoint = '0; actual = 20'sd5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_out("b2b_first", 4, 1, 5, 5, 1'b0);
    @(negedge clk);
    check("b2b_second_valid", 32'(out_valid), 1);
    check("b2b_second_ch",    32'(out_ch), 1);
    check("b2b_second_int",   integral_result, 10);
    check("b2b_second_pi",    pi_result, 10);

    set_gain(0, 0, 1);
    send(0, 0, 0);
    expect_out("ch0_untouched", 5, 0, 6, 6, 1'b0);

    // Clear sequence, with a stray clear_req while already clearing.
    @(posedge clk); #1;
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    lows = 0;
    seen_high = 1'b0;
    for (int k = 0; k < CH + 2; k++) begin
      @(negedge clk);
      if (k == 1) clear_req = 1'b1;
      if (k == 2) clear_req = 1'b0;
      if (!in_ready && !seen_high) lows++;
      else if (in_ready)           seen_high = 1'b1;
    end
    check("clear_ready_low_cycles", lows, CH);
    check("clear_ready_after",      32'(in_ready), 1);

    send(0, 0, 0);
    expect_out("clear_ch0", 5, 0, 0, 0, 1'b0);
    send(2, 0, 3);
    expect_out("clear_ch2", 5, 2, 3, 3, 1'b0);

    // Mid-stream reset discards in-flight samples and zeroes integrals.
    @(posedge clk); #1;
    in_valid = 1'b1; in_ch = 2'd0; setpoint = '0; actual = 20'sd7;
    repeat (3) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_L = 1'b0;
    @(negedge clk);
    check("mid_rst_pi",  pi_result, 0);
    check("mid_rst_int", integral_result, 0);
    check("mid_rst_ch",  32'(out_ch), 0);
    check("mid_rst_sat", 32'(sat_flag), 0);
    @(posedge clk); #1;
    rst_L = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid_rst_no_output", seen, 0);
    check("mid_rst_in_ready",  32'(in_ready), 1);
    send(0, 0, 1);
    expect_out("post_rst", 5, 0, 1, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
